// File: rtl/lc3_mem_responder_if.sv
// lc3_mem_responder_if: fetch, data-access and side-load signals between the LC3 core/bench and the memory model
interface lc3_mem_responder_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_req;
  logic [15:0] Data_addr;
  logic        Data_rd;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        load_en;
  logic        load_sel;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        oor_err;
  modport master (
    output pc, instrmem_rd, data_req, Data_addr, Data_rd, Data_din,
           load_en, load_sel, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data, oor_err
  );
  modport slave (
    input  pc, instrmem_rd, data_req, Data_addr, Data_rd, Data_din,
           load_en, load_sel, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data, oor_err
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: fixed-latency instruction/data memory model for the LC3 core; define LC3_MEM_RANGE_CHK_EN to enable range checking
module lc3_mem_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'h3000,
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter int          INSTR_LAT  = 1,
  parameter int          DATA_LAT   = 2
) (
  input logic                clock,
  input logic                reset,
  lc3_mem_responder_if.slave bus
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
`ifdef LC3_MEM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic in_rng(input logic [15:0] a, input int depth);
    return {1'b0, 16'(a - BASE_ADDR)} < 17'(depth);
  endfunction
  logic [15:0] imem_q [IMEM_DEPTH];
  logic [15:0] dmem_q [DMEM_DEPTH];
  state_t      i_st_q, d_st_q;
  logic [15:0] i_cnt_q, i_addr_q, i_hold_q;
  logic [15:0] d_cnt_q, d_addr_q, d_din_q, d_hold_q;
  logic        i_cmp_q, d_cmp_q, d_rd_q;
  logic [15:0] i_word, d_word;
  logic        d_we, ld_ok;
  // out-of-range words read as DEAD only when range checking is built in
  assign i_word = (CHK && !in_rng(i_addr_q, IMEM_DEPTH)) ? 16'hDEAD : imem_q[IW'(i_addr_q - BASE_ADDR)];
  assign d_word = (CHK && !in_rng(d_addr_q, DMEM_DEPTH)) ? 16'hDEAD : dmem_q[DW'(d_addr_q - BASE_ADDR)];
  assign d_we   = d_st_q == DONE && !d_rd_q && (!CHK || in_rng(d_addr_q, DMEM_DEPTH));
  assign ld_ok  = !CHK || in_rng(bus.load_addr, bus.load_sel ? DMEM_DEPTH : IMEM_DEPTH);
  // read data is shown live from the array during DONE, otherwise the last read is held
  assign bus.Instr_dout     = i_st_q == DONE ? i_word : i_hold_q;
  assign bus.Data_dout      = (d_st_q == DONE && d_rd_q) ? d_word : d_hold_q;
  assign bus.complete_instr = i_cmp_q;
  assign bus.complete_data  = d_cmp_q;
  // arrays survive reset; a side-load is issued after the data write so it wins on a collision
  always_ff @(posedge clock) begin
    if (d_we) dmem_q[DW'(d_addr_q - BASE_ADDR)] <= d_din_q;
    if (bus.load_en && ld_ok && bus.load_sel) dmem_q[DW'(bus.load_addr - BASE_ADDR)] <= bus.load_data;
    if (bus.load_en && ld_ok && !bus.load_sel) imem_q[IW'(bus.load_addr - BASE_ADDR)] <= bus.load_data;
  end
  // fetch port: accept in IDLE, count out LAT-1 busy cycles, pulse completion for one DONE cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_st_q   <= IDLE;
      i_cnt_q  <= '0;
      i_addr_q <= '0;
      i_hold_q <= '0;
      i_cmp_q  <= 1'b0;
    end else begin
      i_cmp_q <= 1'b0;
      case (i_st_q)
        IDLE: if (bus.instrmem_rd) begin
          i_addr_q <= bus.pc;
          i_cnt_q  <= 16'(INSTR_LAT - 1);
          i_st_q   <= (INSTR_LAT == 1) ? DONE : BUSY;
          i_cmp_q  <= (INSTR_LAT == 1);
        end
        BUSY: begin
          i_cnt_q <= i_cnt_q - 16'd1;
          i_st_q  <= (i_cnt_q == 16'd1) ? DONE : BUSY;
          i_cmp_q <= (i_cnt_q == 16'd1);
        end
        DONE: begin
          i_hold_q <= i_word;
          i_st_q   <= IDLE;
        end
        default: i_st_q <= IDLE;
      endcase
    end
  end
  // data port: same sequencing, also latching direction and write data at accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_st_q   <= IDLE;
      d_cnt_q  <= '0;
      d_addr_q <= '0;
      d_din_q  <= '0;
      d_rd_q   <= 1'b0;
      d_hold_q <= '0;
      d_cmp_q  <= 1'b0;
    end else begin
      d_cmp_q <= 1'b0;
      case (d_st_q)
        IDLE: if (bus.data_req) begin
          d_addr_q <= bus.Data_addr;
          d_rd_q   <= bus.Data_rd;
          d_din_q  <= bus.Data_din;
          d_cnt_q  <= 16'(DATA_LAT - 1);
          d_st_q   <= (DATA_LAT == 1) ? DONE : BUSY;
          d_cmp_q  <= (DATA_LAT == 1);
        end
        BUSY: begin
          d_cnt_q <= d_cnt_q - 16'd1;
          d_st_q  <= (d_cnt_q == 16'd1) ? DONE : BUSY;
          d_cmp_q <= (d_cnt_q == 16'd1);
        end
        DONE: begin
          d_hold_q <= d_rd_q ? d_word : d_hold_q;
          d_st_q   <= IDLE;
        end
        default: d_st_q <= IDLE;
      endcase
    end
  end
`ifdef LC3_MEM_RANGE_CHK_EN
  logic oor_q;
  // sticky flag for any out-of-range accept or side-load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) oor_q <= 1'b0;
    else if ((i_st_q == IDLE && bus.instrmem_rd && !in_rng(bus.pc, IMEM_DEPTH)) ||
             (d_st_q == IDLE && bus.data_req && !in_rng(bus.Data_addr, DMEM_DEPTH)) ||
             (bus.load_en && !ld_ok)) oor_q <= 1'b1;
  end
  assign bus.oor_err = oor_q;
`else
  assign bus.oor_err = 1'b0;
`endif
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: two responders (data latency 2 and 3) against a cycle-numbered transaction model
module tb_lc3_mem_responder;
`ifdef LC3_MEM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int ILAT = 1;
  typedef struct packed {
    logic        rv, ir;
    logic [15:0] pc;
    logic        dr;
    logic [15:0] da;
    logic        drd;
    logic [15:0] din;
    logic        le, ls;
    logic [15:0] la, ld;
  } stim_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  lc3_mem_responder_if bus0 ();
  lc3_mem_responder_if bus1 ();
  lc3_mem_responder #(.INSTR_LAT(1), .DATA_LAT(2)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
  lc3_mem_responder #(.INSTR_LAT(1), .DATA_LAT(3)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  int n_checks = 0;
  int n_errors = 0;
  int c = 0;
  int dlat [2] = '{2, 3};
  int i_done = -1, i_free = 0;
  logic [15:0] i_addr = '0, i_hold = '0;
  int d_done [2] = '{-1, -1};
  int d_free [2] = '{0, 0};
  logic [15:0] d_addr [2], d_din [2];
  logic [15:0] d_hold [2] = '{16'h0, 16'h0};
  logic d_rd [2];
  bit oor_m [2] = '{1'b0, 1'b0};
  logic [15:0] imem_m [256];
  logic [15:0] dmem_m [2][256];
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit inr(input logic [15:0] a);
    return ((int'(a) - 'h3000) & 'hFFFF) < 256;
  endfunction
  function automatic int mi(input logic [15:0] a);
    return (int'(a) - 'h3000) & 255;
  endfunction
  function automatic logic [15:0] word_i(input logic [15:0] a);
    return (CHK && !inr(a)) ? 16'hDEAD : imem_m[mi(a)];
  endfunction
  function automatic logic [15:0] word_d(input int k, input logic [15:0] a);
    return (CHK && !inr(a)) ? 16'hDEAD : dmem_m[k][mi(a)];
  endfunction
  function automatic stim_t idle();
    stim_t s = '0;
    s.rv = 1'b1;
    return s;
  endfunction
  function automatic logic [15:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(16'h3000 + $urandom_range(0, 255));
  endfunction
  // one clock cycle: check outputs of this cycle, drive its inputs, then advance the model past its closing edge
  task automatic cyc(input stim_t s);
    @(negedge clock);
    c++;
    if (c == i_done) i_hold = word_i(i_addr);
    for (int k = 0; k < 2; k++) if (c == d_done[k] && d_rd[k]) d_hold[k] = word_d(k, d_addr[k]);
    check($sformatf("ci0@%0d", c), 16'(bus0.complete_instr), 16'(c == i_done));
    check($sformatf("ci1@%0d", c), 16'(bus1.complete_instr), 16'(c == i_done));
    check($sformatf("id0@%0d", c), bus0.Instr_dout, i_hold);
    check($sformatf("id1@%0d", c), bus1.Instr_dout, i_hold);
    check($sformatf("cd0@%0d", c), 16'(bus0.complete_data), 16'(c == d_done[0]));
    check($sformatf("cd1@%0d", c), 16'(bus1.complete_data), 16'(c == d_done[1]));
    check($sformatf("dd0@%0d", c), bus0.Data_dout, d_hold[0]);
    check($sformatf("dd1@%0d", c), bus1.Data_dout, d_hold[1]);
    check($sformatf("oor0@%0d", c), 16'(bus0.oor_err), 16'(oor_m[0]));
    check($sformatf("oor1@%0d", c), 16'(bus1.oor_err), 16'(oor_m[1]));
    reset = s.rv;
    bus0.instrmem_rd = s.ir; bus1.instrmem_rd = s.ir;
    bus0.pc = s.pc;          bus1.pc = s.pc;
    bus0.data_req = s.dr;    bus1.data_req = s.dr;
    bus0.Data_addr = s.da;   bus1.Data_addr = s.da;
    bus0.Data_rd = s.drd;    bus1.Data_rd = s.drd;
    bus0.Data_din = s.din;   bus1.Data_din = s.din;
    bus0.load_en = s.le;     bus1.load_en = s.le;
    bus0.load_sel = s.ls;    bus1.load_sel = s.ls;
    bus0.load_addr = s.la;   bus1.load_addr = s.la;
    bus0.load_data = s.ld;   bus1.load_data = s.ld;
    if (!s.rv) begin
      i_done = -1; i_free = 0; i_hold = '0;
      for (int k = 0; k < 2; k++) begin
        d_done[k] = -1; d_free[k] = 0; d_hold[k] = '0; oor_m[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (c == d_done[k] && !d_rd[k] && (!CHK || inr(d_addr[k]))) dmem_m[k][mi(d_addr[k])] = d_din[k];
      if (s.ir && c >= i_free) begin
        i_addr = s.pc; i_done = c + ILAT; i_free = c + ILAT + 1;
        if (CHK && !inr(s.pc)) oor_m = '{1'b1, 1'b1};
      end
      for (int k = 0; k < 2; k++)
        if (s.dr && c >= d_free[k]) begin
          d_addr[k] = s.da; d_rd[k] = s.drd; d_din[k] = s.din;
          d_done[k] = c + dlat[k]; d_free[k] = c + dlat[k] + 1;
          if (CHK && !inr(s.da)) oor_m[k] = 1'b1;
        end
      if (s.le) begin
        if (CHK && !inr(s.la)) oor_m = '{1'b1, 1'b1};
        else if (s.ls) begin
          dmem_m[0][mi(s.la)] = s.ld; dmem_m[1][mi(s.la)] = s.ld;
        end else imem_m[mi(s.la)] = s.ld;
      end
    end
  endtask
  initial begin
    stim_t s;
    #2 reset = 1'b0;
    s = '0;
    cyc(s); cyc(s);
    for (int i = 0; i < 512; i++) begin
      s = idle(); s.le = 1'b1; s.ls = (i >= 256); s.la = 16'(16'h3000 + (i & 255)); s.ld = 16'($urandom);
      cyc(s);
    end
    s = idle(); s.le = 1'b1; s.la = 16'h3000; s.ld = 16'h1261; cyc(s);
    s.ls = 1'b1; s.la = 16'h3020; s.ld = 16'h7777; cyc(s);
    s.la = 16'h30FF; s.ld = 16'h0FF0; cyc(s);
    s.la = 16'h3040; s.ld = 16'h1234; cyc(s);
    s = idle(); s.ir = 1'b1; s.pc = 16'h3000; s.dr = 1'b1; s.da = 16'h3010; s.din = 16'hBEEF; cyc(s);
    cyc(idle());
    check("fetch_cmp", 16'(bus0.complete_instr), 16'h1);
    check("fetch_data", bus0.Instr_dout, 16'h1261);
    check("wr_early", 16'(bus0.complete_data), 16'h0);
    cyc(idle());
    check("wr_cmp0", 16'(bus0.complete_data), 16'h1);
    check("wr_wait1", 16'(bus1.complete_data), 16'h0);
    cyc(idle());
    check("wr_cmp1", 16'(bus1.complete_data), 16'h1);
    cyc(idle());
    s = idle(); s.ir = 1'b1; s.pc = 16'h3000; s.dr = 1'b1; s.da = 16'h3010; s.drd = 1'b1; cyc(s);
    s = idle(); s.da = 16'h3020; s.drd = 1'b0; cyc(s);
    check("conc_icmp", 16'(bus1.complete_instr), 16'h1);
    check("conc_idata", bus1.Instr_dout, 16'h1261);
    cyc(idle());
    check("rd0_cmp", 16'(bus0.complete_data), 16'h1);
    check("rd0_data", bus0.Data_dout, 16'hBEEF);
    cyc(idle());
    check("rd1_cmp", 16'(bus1.complete_data), 16'h1);
    check("rd1_data", bus1.Data_dout, 16'hBEEF);
    check("rd0_hold", bus0.Data_dout, 16'hBEEF);
    cyc(idle());
    s = idle(); s.dr = 1'b1; s.da = 16'h3040; s.din = 16'h5555; cyc(s);
    s = '0; cyc(s); cyc(s);
    check("rst_dd", bus0.Data_dout, 16'h0);
    check("rst_id", bus0.Instr_dout, 16'h0);
    check("rst_cd", 16'(bus1.complete_data), 16'h0);
    repeat (4) cyc(idle());
    s = idle(); s.dr = 1'b1; s.da = 16'h3040; s.drd = 1'b1; cyc(s);
    cyc(idle()); cyc(idle());
    check("abort0", bus0.Data_dout, 16'h1234);
    cyc(idle());
    check("abort1", bus1.Data_dout, 16'h1234);
    cyc(idle());
    s = idle(); s.dr = 1'b1; s.da = 16'h2FFF; s.drd = 1'b1; cyc(s);
    cyc(idle()); cyc(idle());
    check("rng_data", bus0.Data_dout, CHK ? 16'hDEAD : 16'h0FF0);
    cyc(idle());
    check("rng_oor", 16'(bus0.oor_err), 16'(CHK));
    repeat (3) cyc(idle());
    check("rng_sticky", 16'(bus1.oor_err), 16'(CHK));
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rv  = ($urandom_range(0, 149) != 0);
      s.ir  = 1'($urandom);
      s.pc  = rnd_addr();
      s.dr  = 1'($urandom);
      s.da  = rnd_addr();
      s.drd = 1'($urandom);
      s.din = 16'($urandom);
      s.le  = s.rv && ($urandom_range(0, 3) == 0);
      s.ls  = 1'($urandom);
      s.la  = rnd_addr();
      s.ld  = 16'($urandom);
      cyc(s);
    end
    cyc(idle()); cyc(idle());
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
